// File: rtl/pipe_compar_n_pkg.sv
// Shared types and helpers for the pipelined N-bit magnitude comparator.
// A slice result is a {greater, equal} pair; the merge function combines two adjacent slices.
// Elaboration helpers derive the slice count, tree depth and node offsets from WIDTH/CHUNK.
package cmp_pkg;

  typedef struct packed {
    logic g;
    logic e;
  } cmp_res_t;

  // The more significant slice decides unless it is equal, in which case the lower one decides.
  function automatic cmp_res_t cmp_merge(input cmp_res_t hi, input cmp_res_t lo);
    cmp_res_t r;
    r.g = hi.g | (hi.e & lo.g);
    r.e = hi.e & lo.e;
    return r;
  endfunction

  function automatic int cmp_nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int cmp_lvl(input int width, input int chunk);
    return $clog2(width / chunk);
  endfunction

  // Tree nodes are stored flat, leaves first; level l starts at this offset.
  function automatic int cmp_off(input int nch, input int lvl);
    return 2 * nch - 2 * (nch >> lvl);
  endfunction

endpackage

// File: rtl/pipe_compar_n_if.sv
// Handshake and data bundle between a producer/consumer and the comparator pipeline.
// The master side offers operands and accepts results; the slave side is the comparator.
// signed_mode exists only when CMP_SIGNED_EN is defined.
interface pipe_compar_n_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] in_tag;
`ifdef CMP_SIGNED_EN
  logic             signed_mode;
`endif
  logic             out_valid;
  logic             out_ready;
  logic             gr;
  logic             eq;
  logic             lt;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, a, b, in_tag,
`ifdef CMP_SIGNED_EN
    output signed_mode,
`endif
    output out_ready,
    input  in_ready, out_valid, gr, eq, lt, out_tag
  );

  modport slave (
    input  in_valid, a, b, in_tag,
`ifdef CMP_SIGNED_EN
    input  signed_mode,
`endif
    input  out_ready,
    output in_ready, out_valid, gr, eq, lt, out_tag
  );

endinterface

// File: rtl/pipe_compar_n_merge_stage.sv
// One level of the comparison tree: IN_N slice results reduced pairwise to IN_N/2, registered.
// Latency: 1 cycle.
// Backpressure: loads its predecessor (bubbles included) only when advance is high, else holds.
module cmp_merge_stage
  import cmp_pkg::*;
#(
  parameter int IN_N  = 2,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   advance,
  input  logic                   in_vld,
  input  logic [TAG_W-1:0]       in_tag,
  input  cmp_res_t [IN_N-1:0]    in_res,
  output logic                   out_vld,
  output logic [TAG_W-1:0]       out_tag,
  output cmp_res_t [IN_N/2-1:0]  out_res
);

  localparam int OUT_N = IN_N / 2;

  logic                  vld_d, vld_q;
  logic [TAG_W-1:0]      tag_d, tag_q;
  cmp_res_t [OUT_N-1:0]  res_d, res_q;
  cmp_res_t [OUT_N-1:0]  merged;

  // Pairwise merge; the odd (upper) index of each pair is the more significant slice.
  always_comb begin
    merged = '0;
    for (int j = 0; j < OUT_N; j++) begin
      merged[j] = cmp_merge(in_res[2*j+1], in_res[2*j]);
    end
  end

  // Next state: valid follows the predecessor on advance; data only captured for real items.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    res_d = res_q;
    if (advance) begin
      vld_d = in_vld;
      if (in_vld) begin
        tag_d = in_tag;
        res_d = merged;
      end
    end
  end

  // Valid bit is reset so in-flight items are discarded; payload is don't-care while invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= 1'b0;
    else       vld_q <= vld_d;
  end

  // Payload registers, qualified by the valid bit downstream.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    res_q <= res_d;
  end

  assign out_vld = vld_q;
  assign out_tag = tag_q;
  assign out_res = res_q;

endmodule

// File: rtl/pipe_compar_n.sv
// Pipelined WIDTH-bit magnitude comparator (gr/eq/lt) with a tag carried alongside each result.
// Latency: 1 + log2(WIDTH/CHUNK) cycles; throughput one result per clock.
// Backpressure: whole pipeline stalls when out_valid & ~out_ready; in_ready = ~out_valid | out_ready.
// Optional macro CMP_SIGNED_EN adds signed_mode for two's-complement comparison.
module pipe_compar_n
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4,
  parameter int TAG_W = 4
) (
  input logic             clk,
  input logic             reset,
  pipe_compar_n_if.slave  bus
);

  localparam int NCH   = cmp_nch(WIDTH, CHUNK);
  localparam int LVL   = cmp_lvl(WIDTH, CHUNK);
  localparam int NODES = 2 * NCH - 1;

  if (CHUNK < 1 || WIDTH != CHUNK * (1 << LVL)) begin : g_bad_cfg
    $error("pipe_compar_n: WIDTH must equal CHUNK * 2^k");
  end

  logic                        advance;
  logic [WIDTH-1:0]            a_cmp, b_cmp;
  cmp_res_t [NCH-1:0]          leaf_cmp;
  cmp_res_t [NCH-1:0]          leaf_d, leaf_q;
  logic                        leaf_vld_d, leaf_vld_q;
  logic [TAG_W-1:0]            leaf_tag_d, leaf_tag_q;

  cmp_res_t [NODES-1:0]        tree_res;
  logic [LVL:0]                lvl_vld;
  logic [LVL:0][TAG_W-1:0]     lvl_tag;

  cmp_res_t                    fin_res;
  logic                        fin_vld;

  // Operand conditioning: flipping both MSBs turns a signed compare into an unsigned one.
  always_comb begin
    a_cmp = bus.a;
    b_cmp = bus.b;
`ifdef CMP_SIGNED_EN
    if (bus.signed_mode) begin
      a_cmp[WIDTH-1] = ~bus.a[WIDTH-1];
      b_cmp[WIDTH-1] = ~bus.b[WIDTH-1];
    end
`endif
  end

  // Per-slice compare; slice i covers bits [i*CHUNK +: CHUNK], higher index is more significant.
  always_comb begin
    leaf_cmp = '0;
    for (int i = 0; i < NCH; i++) begin
      leaf_cmp[i].g = a_cmp[i*CHUNK +: CHUNK] >  b_cmp[i*CHUNK +: CHUNK];
      leaf_cmp[i].e = a_cmp[i*CHUNK +: CHUNK] == b_cmp[i*CHUNK +: CHUNK];
    end
  end

  // Leaf stage next state: accept on advance (bubble if in_valid is low), else hold.
  always_comb begin
    leaf_vld_d = leaf_vld_q;
    leaf_tag_d = leaf_tag_q;
    leaf_d     = leaf_q;
    if (advance) begin
      leaf_vld_d = bus.in_valid;
      if (bus.in_valid) begin
        leaf_tag_d = bus.in_tag;
        leaf_d     = leaf_cmp;
      end
    end
  end

  // Leaf valid bit, cleared asynchronously so nothing survives reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) leaf_vld_q <= 1'b0;
    else       leaf_vld_q <= leaf_vld_d;
  end

  // Leaf payload, meaningful only while its valid bit is set.
  always_ff @(posedge clk) begin
    leaf_tag_q <= leaf_tag_d;
    leaf_q     <= leaf_d;
  end

  assign tree_res[NCH-1:0] = leaf_q;
  assign lvl_vld[0]        = leaf_vld_q;
  assign lvl_tag[0]        = leaf_tag_q;

  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    localparam int IN_N  = NCH >> l;
    localparam int OFF_I = cmp_off(NCH, l);
    localparam int OFF_O = cmp_off(NCH, l + 1);

    cmp_merge_stage #(
      .IN_N  (IN_N),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .advance (advance),
      .in_vld  (lvl_vld[l]),
      .in_tag  (lvl_tag[l]),
      .in_res  (tree_res[OFF_I +: IN_N]),
      .out_vld (lvl_vld[l+1]),
      .out_tag (lvl_tag[l+1]),
      .out_res (tree_res[OFF_O +: IN_N/2])
    );
  end

  assign fin_res = tree_res[NODES-1];
  assign fin_vld = lvl_vld[LVL];

  // Single global advance: every stage moves together unless the output is stuck.
  assign advance      = ~fin_vld | bus.out_ready;
  assign bus.in_ready = advance;

  // Outputs are qualified by valid so they read zero whenever nothing is presented.
  assign bus.out_valid = fin_vld;
  assign bus.gr        = fin_vld & fin_res.g;
  assign bus.eq        = fin_vld & fin_res.e;
  assign bus.lt        = fin_vld & ~fin_res.g & ~fin_res.e;
  assign bus.out_tag   = fin_vld ? lvl_tag[LVL] : '0;

endmodule

// File: tb/tb_pipe_compar_n.sv
// Bench for pipe_compar_n: a 32/4 instance for directed sequences and an 8/4 instance for random traffic.
// Results are checked against a queue-based reference computed with plain integer comparison.
module tb_pipe_compar_n;

  logic clk;
  logic reset;

  pipe_compar_n_if #(.WIDTH(32), .TAG_W(4)) b32 ();
  pipe_compar_n_if #(.WIDTH(8),  .TAG_W(8)) b8 ();

  pipe_compar_n #(.WIDTH(32), .CHUNK(4), .TAG_W(4)) u_dut32 (.clk(clk), .reset(reset), .bus(b32));
  pipe_compar_n #(.WIDTH(8),  .CHUNK(4), .TAG_W(8)) u_dut8  (.clk(clk), .reset(reset), .bus(b8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [2:0]  exp_gel;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  tag;
    logic        sm;
  } item_t;

  vec_t  vecs[10];
  item_t q32[$];
  item_t q8[$];
  int    nvec = 0;
  int    nmiss = 0;
  int    ret32 = 0;
  int    ret8 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: interpret operands as integers (signed when sm) and compare arithmetically.
  function automatic logic [2:0] ref3(input logic [31:0] a, input logic [31:0] b,
                                      input logic sm, input int w);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    return {sa > sb, sa == sb, sa < sb};
  endfunction

  task automatic step32(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic sm, input logic ordy, output logic took);
    item_t it;
    logic [2:0] e;
    b32.in_valid = iv;
    b32.a = a;
    b32.b = b;
    b32.in_tag = tag;
    b32.out_ready = ordy;
`ifdef CMP_SIGNED_EN
    b32.signed_mode = sm;
`endif
    #1;
    took = iv & b32.in_ready;
    if (took) begin
      it.a = a; it.b = b; it.tag = {4'd0, tag}; it.sm = sm;
      q32.push_back(it);
    end
    if (b32.out_valid && ordy) begin
      ret32++;
      if (q32.size() == 0) chk("res32_extra", 1, 0);
      else begin
        it = q32.pop_front();
        e = ref3(it.a, it.b, it.sm, 32);
        chk("res32", {b32.gr, b32.eq, b32.lt, b32.out_tag}, {e, it.tag[3:0]});
      end
    end
    @(negedge clk);
  endtask

  task automatic step8(input logic iv, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] tag, input logic ordy, output logic took);
    item_t it;
    logic [2:0] e;
    b8.in_valid = iv;
    b8.a = a;
    b8.b = b;
    b8.in_tag = tag;
    b8.out_ready = ordy;
    #1;
    took = iv & b8.in_ready;
    if (took) begin
      it.a = {24'd0, a}; it.b = {24'd0, b}; it.tag = tag; it.sm = 1'b0;
      q8.push_back(it);
    end
    if (b8.out_valid && ordy) begin
      ret8++;
      if (q8.size() == 0) chk("res8_extra", 1, 0);
      else begin
        it = q8.pop_front();
        e = ref3(it.a, it.b, 1'b0, 8);
        chk($sformatf("rand8 a=%0h b=%0h", it.a[7:0], it.b[7:0]),
            {b8.gr, b8.eq, b8.lt, b8.out_tag}, {e, it.tag});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic        took;
    int          lat;
    int          sent;
    int          cyc;
    int          idx;
    logic [31:0] ba[8];
    logic [31:0] bb[8];
    logic [6:0]  snap;
    logic [7:0]  ra, rb;

    vecs[0] = '{32'h8000_0000, 32'h7FFF_FFFF, 4'd0, 3'b100};
    vecs[1] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd1, 3'b010};
    vecs[2] = '{32'h0000_0001, 32'h0000_0002, 4'd2, 3'b001};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 4'd3, 3'b010};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 4'd4, 3'b100};
    vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 4'd5, 3'b001};
    vecs[6] = '{32'h1234_5678, 32'h1234_5679, 4'd6, 3'b001};
    vecs[7] = '{32'h1234_5679, 32'h1234_5678, 4'd7, 3'b100};
    vecs[8] = '{32'hF000_0000, 32'h0FFF_FFFF, 4'd8, 3'b100};
    vecs[9] = '{32'h7FFF_FFFF, 32'h8000_0000, 4'd9, 3'b001};

    reset = 1'b1;
    b32.in_valid = 0; b32.a = 0; b32.b = 0; b32.in_tag = 0; b32.out_ready = 1;
    b8.in_valid = 0;  b8.a = 0;  b8.b = 0;  b8.in_tag = 0;  b8.out_ready = 1;
`ifdef CMP_SIGNED_EN
    b32.signed_mode = 0;
    b8.signed_mode = 0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_out32", {b32.out_valid, b32.gr, b32.eq, b32.lt, b32.out_tag}, 0);
    chk("rst_out8", {b8.out_valid, b8.gr, b8.eq, b8.lt, b8.out_tag}, 0);
    reset = 1'b0;
    #1;
    chk("rdy_after_rst32", b32.in_ready, 1);
    chk("rdy_after_rst8", b8.in_ready, 1);
    @(negedge clk);

    // Single transaction latency.
    b32.in_valid = 1; b32.a = 32'h8000_0000; b32.b = 32'h7FFF_FFFF; b32.in_tag = 4'd3;
    b32.out_ready = 1;
    @(negedge clk);
    b32.in_valid = 0;
    lat = 1;
    while (!b32.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 4);
    chk("first_res", {b32.gr, b32.eq, b32.lt, b32.out_tag}, {3'b100, 4'd3});
    @(negedge clk);
    chk("first_retired", b32.out_valid, 0);

    // Back-to-back stream from the vector table.
    for (int c = 0; c < 14; c++) begin
      if (c < 10) begin
        b32.in_valid = 1; b32.a = vecs[c].a; b32.b = vecs[c].b; b32.in_tag = vecs[c].tag;
      end else begin
        b32.in_valid = 0;
      end
      #1;
      if (c < 10) chk($sformatf("stream_rdy%0d", c), b32.in_ready, 1);
      if (c >= 4) begin
        chk($sformatf("stream_vld%0d", c - 4), b32.out_valid, 1);
        chk($sformatf("stream_res%0d", c - 4), {b32.gr, b32.eq, b32.lt, b32.out_tag},
            {vecs[c-4].exp_gel, vecs[c-4].tag});
      end else begin
        chk($sformatf("stream_idle%0d", c), b32.out_valid, 0);
      end
      @(negedge clk);
    end

    // Backpressure: fill with out_ready low, hold 5 cycles, release and drain.
    for (int i = 0; i < 8; i++) begin
      ba[i] = $urandom;
      bb[i] = (i == 3) ? ba[i] : $urandom;
    end
    sent = 0; cyc = 0; ret32 = 0;
    while (!b32.out_valid && cyc < 20) begin
      step32(1, ba[sent], bb[sent], sent[3:0], 0, 0, took);
      if (took) sent++;
      cyc++;
    end
    chk("bp_fill_count", sent, 4);
    snap = {b32.gr, b32.eq, b32.lt, b32.out_tag};
    chk("bp_head", snap, {ref3(ba[0], bb[0], 0, 32), 4'd0});
    for (int k = 0; k < 5; k++) begin
      b32.in_valid = 1; b32.a = ba[sent]; b32.b = bb[sent]; b32.in_tag = sent[3:0];
      b32.out_ready = 0;
      #1;
      chk($sformatf("bp_rdy_low%0d", k), b32.in_ready, 0);
      chk($sformatf("bp_frozen%0d", k), {b32.out_valid, b32.gr, b32.eq, b32.lt, b32.out_tag},
          {1'b1, snap});
      @(negedge clk);
    end
    cyc = 0;
    while ((sent < 8 || q32.size() != 0) && cyc < 60) begin
      idx = (sent < 8) ? sent : 7;
      step32(sent < 8, ba[idx], bb[idx], idx[3:0], 0, 1, took);
      if (took) sent++;
      cyc++;
    end
    chk("bp_sent", sent, 8);
    chk("bp_retired", ret32, 8);
    chk("bp_queue_empty", q32.size(), 0);

    // Reset with items in flight.
    cyc = 0;
    while (!b32.out_valid && cyc < 20) begin
      step32(1, $urandom, $urandom, cyc[3:0], 0, 0, took);
      cyc++;
    end
    chk("flight_full", b32.out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out", {b32.out_valid, b32.gr, b32.eq, b32.lt, b32.out_tag}, 0);
    q32.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rdy_after_midrst", b32.in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      step32(0, 0, 0, 0, 0, 1, took);
      chk($sformatf("no_stale%0d", k), b32.out_valid, 0);
    end

`ifdef CMP_SIGNED_EN
    // Signed vs unsigned interpretation of the same operands.
    step32(1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd1, 1, 1, took);
    step32(1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd2, 0, 1, took);
    step32(1, 32'h8000_0000, 32'h7FFF_FFFF, 4'd3, 1, 1, took);
    for (int k = 0; k < 8; k++) step32(0, 0, 0, 0, 0, 1, took);
    chk("signed_drained", q32.size(), 0);
`endif

    // Random 8-bit traffic with random valid and ready.
    sent = 0; cyc = 0; ret8 = 0;
    while (ret8 < 300 && cyc < 5000) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      step8((sent < 300) && ($urandom_range(0, 3) != 0), ra, rb, sent[7:0],
            $urandom_range(0, 3) != 0, took);
      if (took) sent++;
      cyc++;
    end
    chk("rand_retired", ret8, 300);
    chk("rand_queue_empty", q8.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
